// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//
// Bitwise half-adder slice over a WIDTH-bit vector. Each bit position is an
// independent half adder: SUM = A ^ B and CARRY = A & B, with no carry moving
// between slices. This is the leaf cell used to build full adders and
// ripple-carry chains. Two instances plus an OR gate form one full-adder bit.
//
// Besides the zero-latency combinational outputs, the block keeps a
// registered, valid-qualified copy of the result for pipelined datapaths. It
// also keeps a sticky flag that remembers whether any captured result
// produced a carry.
//
// Ports
//   clk          rising-edge clock for the registered path
//   rst_n        asynchronous, active-low reset of the registered path
//   A, B         operands, one bit per slice
//   in_valid     A/B are captured into the registered path on this edge
//   flag_clr     synchronous clear of carry_sticky (wins over a set)
//   SUM, CARRY   combinational per-slice sum and carry
//   sum_q        registered SUM, updated only when in_valid
//   carry_q      registered CARRY, updated only when in_valid
//   out_valid    sum_q/carry_q were loaded on the previous edge
//   carry_any    combinational OR of all CARRY bits
//   carry_sticky set once any captured CARRY bit was 1, cleared by flag_clr
// ---------------------------------------------------------------------------
module half_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] SUM,
    output logic [WIDTH-1:0] CARRY,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic             carry_any,
    output logic             carry_sticky
);

    // Each slice is built on its own so it is obvious in the netlist that no
    // carry travels from one bit position to the next.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign SUM[i]   = A[i] ^ B[i];
        assign CARRY[i] = A[i] & B[i];
    end

    // Any-carry summary for the current operands. It also serves as the set
    // condition of the sticky flag, so the flag and this output agree about
    // what counts as "a carry happened".
    assign carry_any = |CARRY;

    // Registered result. The data registers only load when the operands are
    // qualified, so a consumer can keep reading the last result while the
    // input side idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else if (in_valid) begin
            sum_q   <= SUM;
            carry_q <= CARRY;
        end
    end

    // out_valid is a one-cycle pulse for every capture. Back-to-back
    // in_valid keeps it high with no bubbles. A reset drops it at once,
    // which discards any capture that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Sticky carry flag. The clear is checked first so software can clear
    // and discard a simultaneous carry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_sticky <= 1'b0;
        end else if (flag_clr) begin
            carry_sticky <= 1'b0;
        end else if (in_valid && carry_any) begin
            carry_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// ---------------------------------------------------------------------------
// tb_half_adder
//
// Bench for half_adder. It uses four instances:
//   dut1        WIDTH=1, used for the truth table and the registered path
//   dut4        WIDTH=4, used for the multi-bit combinational cases
//   fa_h1/fa_h2 two WIDTH=1 instances plus an OR, forming a full adder
//
// Registered results are predicted with a scoreboard queue. An entry is
// pushed when a valid operand pair is driven, and popped when out_valid is
// due after the edge.
// ---------------------------------------------------------------------------
module tb_half_adder;

    typedef struct packed {
        logic sum;
        logic carry;
    } res_t;

    logic clk;
    logic rst_n;

    logic a1, b1, iv1, clr1;
    logic sum1, carry1, sumq1, carryq1, ov1, any1, sticky1;

    logic [3:0] a4, b4;
    logic       iv4, clr4;
    logic [3:0] sum4, carry4, sumq4, carryq4;
    logic       ov4, any4, sticky4;

    logic fa_a, fa_b, fa_cin, fa_ctrl;
    logic fa_s1, fa_c1, fa_s2, fa_c2, fa_cout;
    logic fa_any1, fa_any2;
    logic fa_sq1, fa_cq1, fa_ov1, fa_st1;
    logic fa_sq2, fa_cq2, fa_ov2, fa_st2;

    int   checkCount = 0;
    int   passCount  = 0;

    res_t sb[$];
    logic lastSum, lastCarry, modelSticky, expValid;

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(iv1), .flag_clr(clr1),
        .SUM(sum1), .CARRY(carry1), .sum_q(sumq1), .carry_q(carryq1),
        .out_valid(ov1), .carry_any(any1), .carry_sticky(sticky1)
    );

    half_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(iv4), .flag_clr(clr4),
        .SUM(sum4), .CARRY(carry4), .sum_q(sumq4), .carry_q(carryq4),
        .out_valid(ov4), .carry_any(any4), .carry_sticky(sticky4)
    );

    half_adder #(.WIDTH(1)) fa_h1 (
        .clk(clk), .rst_n(rst_n), .A(fa_a), .B(fa_b), .in_valid(fa_ctrl), .flag_clr(fa_ctrl),
        .SUM(fa_s1), .CARRY(fa_c1), .sum_q(fa_sq1), .carry_q(fa_cq1),
        .out_valid(fa_ov1), .carry_any(fa_any1), .carry_sticky(fa_st1)
    );

    half_adder #(.WIDTH(1)) fa_h2 (
        .clk(clk), .rst_n(rst_n), .A(fa_s1), .B(fa_cin), .in_valid(fa_ctrl), .flag_clr(fa_ctrl),
        .SUM(fa_s2), .CARRY(fa_c2), .sum_q(fa_sq2), .carry_q(fa_cq2),
        .out_valid(fa_ov2), .carry_any(fa_any2), .carry_sticky(fa_st2)
    );

    assign fa_cout = fa_c1 | fa_c2;

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and counts a pass or reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Drives dut1 on the falling edge. A valid pair pushes its predicted
    // result, computed as an arithmetic sum, onto the scoreboard.
    task automatic applyStimulus(input logic a, input logic b, input logic iv, input logic clr);
        logic [1:0] total;
        @(negedge clk);
        a1   = a;
        b1   = b;
        iv1  = iv;
        clr1 = clr;
        total = 2'(a) + 2'(b);
        if (iv && rst_n) sb.push_back('{sum: total[0], carry: total[1]});
    endtask

    // Advances one rising edge, updates the bench model, and compares the
    // registered outputs of dut1 just after the edge.
    task automatic stepEdge(input string tag);
        res_t r;
        @(posedge clk);
        expValid = iv1;
        if (clr1) modelSticky = 1'b0;
        else if (iv1 && a1 && b1) modelSticky = 1'b1;
        #1;
        checkOutput({tag, ".out_valid"}, 32'(ov1), 32'(expValid));
        if (expValid && sb.size() > 0) begin
            r = sb.pop_front();
            lastSum   = r.sum;
            lastCarry = r.carry;
        end
        checkOutput({tag, ".sum_q"}, 32'(sumq1), 32'(lastSum));
        checkOutput({tag, ".carry_q"}, 32'(carryq1), 32'(lastCarry));
        checkOutput({tag, ".carry_sticky"}, 32'(sticky1), 32'(modelSticky));
    endtask

    logic [1:0] ttExp[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic       ttAny[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [1:0] faTotal;
        logic [2:0] v;

        rst_n = 1'b1;
        a1 = 0; b1 = 0; iv1 = 0; clr1 = 0;
        a4 = '0; b4 = '0; iv4 = 0; clr4 = 0;
        fa_a = 0; fa_b = 0; fa_cin = 0; fa_ctrl = 0;
        lastSum = 0; lastCarry = 0; modelSticky = 0; expValid = 0;

        // Reset state, applied between clock edges.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst.sum_q", 32'(sumq1), 32'd0);
        checkOutput("rst.carry_q", 32'(carryq1), 32'd0);
        checkOutput("rst.out_valid", 32'(ov1), 32'd0);
        checkOutput("rst.carry_sticky", 32'(sticky1), 32'd0);

        // Truth table with 10-unit holds. Reset is still asserted, which
        // also shows the combinational path ignores it.
        for (int i = 0; i < 4; i++) begin
            v = 3'(i);
            a1 = v[1];
            b1 = v[0];
            #10;
            checkOutput($sformatf("tt%0d.carry_sum", i), 32'({carry1, sum1}), 32'(ttExp[i]));
            checkOutput($sformatf("tt%0d.carry_any", i), 32'(any1), 32'(ttAny[i]));
        end

        // Multi-bit slices.
        a4 = 4'b1100; b4 = 4'b1010; #1;
        checkOutput("w4a.SUM", 32'(sum4), 32'h6);
        checkOutput("w4a.CARRY", 32'(carry4), 32'h8);
        checkOutput("w4a.carry_any", 32'(any4), 32'd1);
        a4 = 4'hF; b4 = 4'hF; #1;
        checkOutput("w4b.SUM", 32'(sum4), 32'h0);
        checkOutput("w4b.CARRY", 32'(carry4), 32'hF);
        a4 = 4'h0; b4 = 4'h5; #1;
        checkOutput("w4c.carry_any", 32'(any4), 32'd0);

        // Release reset on a falling edge.
        applyStimulus(0, 0, 0, 0);
        rst_n = 1'b1;

        // Capture 1+1, then idle: the result holds and valid drops.
        applyStimulus(1, 1, 1, 0);
        stepEdge("cap11");
        applyStimulus(1, 0, 0, 0);
        stepEdge("idle");

        // Back-to-back captures. The sticky flag stays set through 1+0.
        applyStimulus(1, 0, 1, 0);
        stepEdge("b2b0");
        applyStimulus(0, 1, 1, 0);
        stepEdge("b2b1");
        applyStimulus(0, 0, 1, 0);
        stepEdge("b2b2");

        // Clear wins over a simultaneous carry.
        applyStimulus(1, 1, 1, 1);
        stepEdge("clrpri");
        applyStimulus(0, 0, 0, 0);
        stepEdge("clridle");

        // Rebuild state for the async reset test: sticky set, sum_q=1, valid.
        applyStimulus(1, 1, 1, 0);
        stepEdge("pre1");
        applyStimulus(1, 0, 1, 0);
        stepEdge("pre2");

        // Async reset between edges.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst.sum_q", 32'(sumq1), 32'd0);
        checkOutput("arst.carry_q", 32'(carryq1), 32'd0);
        checkOutput("arst.out_valid", 32'(ov1), 32'd0);
        checkOutput("arst.carry_sticky", 32'(sticky1), 32'd0);
        a1 = 1; b1 = 1; #1;
        checkOutput("arst.carry_sum", 32'({carry1, sum1}), 32'b10);
        sb.delete();
        lastSum = 0; lastCarry = 0; modelSticky = 0;

        // Release with in_valid low: no result appears, then a capture works.
        applyStimulus(0, 0, 0, 0);
        rst_n = 1'b1;
        stepEdge("rel");
        applyStimulus(1, 1, 1, 0);
        stepEdge("relcap");

        // Full adder from two half adders plus OR, all eight input sets.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fa_a = v[2]; fa_b = v[1]; fa_cin = v[0];
            #1;
            faTotal = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
            checkOutput($sformatf("fa%0d.cout_sum", i), 32'({fa_cout, fa_s2}), 32'(faTotal));
            checkOutput($sformatf("fa%0d.any", i), 32'(fa_any1 | fa_any2), 32'(faTotal[1]));
        end

        // Instances that never see in_valid must still show reset values.
        checkOutput("idle_regs",
                    32'({sumq4, carryq4, ov4, sticky4, fa_sq1, fa_cq1, fa_ov1, fa_st1,
                         fa_sq2, fa_cq2, fa_ov2, fa_st2}), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bitwise half-adder slice: SUM = A xor B, CARRY = A and B, per bit, over a WIDTH-bit vector.
- Primary leaf cell for ripple/full-adder construction. Two half_adder instances plus an OR gate form a full adder.
- Provides combinational outputs for structural use.
- Also provides a registered, valid-qualified copy of the outputs and a sticky carry flag, for pipelined datapaths.

Parameters:
- WIDTH, 1, number of independent half-adder bit slices (minimum 1).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand a, one bit per slice.
- B  input  WIDTH  operand b, one bit per slice.
- in_valid  input  1  A/B qualified for capture this cycle.
- flag_clr  input  1  synchronous clear of carry_sticky.
- SUM  output  WIDTH  combinational A ^ B, bitwise.
- CARRY  output  WIDTH  combinational A & B, bitwise.
- sum_q  output  WIDTH  registered SUM.
- carry_q  output  WIDTH  registered CARRY.
- out_valid  output  1  sum_q/carry_q hold a result captured on the previous edge.
- carry_any  output  1  combinational OR-reduction of CARRY.
- carry_sticky  output  1  set when any captured CARRY bit was 1.

Behaviour:
- Combinational path:
  - SUM[i] = A[i] ^ B[i]; CARRY[i] = A[i] & B[i] for every i.
  - No carry propagates between slices.
  - Zero latency; does not depend on clk, rst_n or in_valid.
  - For any i, SUM[i] and CARRY[i] are never both 1; {CARRY[i],SUM[i]} = A[i]+B[i] (range 0..2).
- carry_any = |CARRY. It is combinational and is 0 when CARRY is all zeros.
- Reset (rst_n low, asynchronous):
  - sum_q = 0, carry_q = 0, out_valid = 0, carry_sticky = 0, immediately and regardless of clk.
  - Combinational outputs are unaffected by reset.
  - Release is synchronous to the next rising edge; the first capture can occur on the first edge with rst_n high.
- Registered path, each rising edge with rst_n high:
  - If in_valid = 1: sum_q <= A ^ B, carry_q <= A & B, out_valid <= 1.
  - If in_valid = 0: sum_q and carry_q hold their value; out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle with no bubbles.
  - There is no backpressure.
- carry_sticky, each rising edge with rst_n high:
  - If flag_clr = 1, carry_sticky <= 0. Clear has priority over set in the same cycle.
  - Else if in_valid = 1 and |(A & B) = 1, carry_sticky <= 1.
  - Otherwise it holds.
- Reset asserted mid-stream discards the in-flight capture. out_valid is 0 on the first edge after release unless in_valid = 1 on that edge.
- Inputs X/Z are not handled specially. The bench drives known values only.

Test Plan:
- Exhaustive truth table, WIDTH=1: A,B = 00,01,10,11 with 10-unit holds -> {CARRY,SUM} = 00,01,01,10. carry_any = 0,0,0,1.
- Multi-bit, WIDTH=4: A=4'b1100, B=4'b1010 -> SUM=4'b0110, CARRY=4'b1000. A=4'hF, B=4'hF -> SUM=0, CARRY=4'hF.
- Registered path: in_valid=1 with A=1, B=1 at edge n -> carry_q=1, sum_q=0, out_valid=1 after edge n. At edge n+1 with in_valid=0 -> out_valid=0, carry_q still 1.
- Async reset: assert rst_n=0 between edges while sum_q=1 and out_valid=1 -> sum_q, carry_q, out_valid and carry_sticky all read 0 before the next edge. SUM/CARRY still track A/B.
- Sticky flag: capture A=B=1 -> carry_sticky=1. Capture A=1, B=0 -> it stays 1. Assert flag_clr=1 with in_valid=1 and A=B=1 in the same cycle -> carry_sticky=0.
- Full-adder composition: two instances plus OR, swept over {A,B,Cin} = 0..7 -> {Cout,SUM} equals A+B+Cin for every combination.
